// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
// Holds the word size, the default memory latency, the latency counter width and the
// arbiter state encoding, so no other file redefines them.
package mem_arbiter_pkg;

    localparam int unsigned WordSize   = 16;
    localparam int unsigned MemLatency = 2;
    localparam int unsigned CntWidth   = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2
    } arbState_e;

endpackage

// File: rtl/mem_latency_counter.sv
// Cycle counter for one memory access.
// Ports:
//   clk_i      - rising-edge clock
//   reset_i    - synchronous active-high reset
//   clear_i    - return the count to zero (wins over enable_i)
//   enable_i   - advance the count by one this cycle
//   terminal_o - high while enabled and the count equals Latency-1
module mem_latency_counter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned Latency = MemLatency
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [CntWidth-1:0] TermCount = CntWidth'(Latency - 1);

    logic [CntWidth-1:0] cntQ;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cntQ <= '0;
        end else if (enable_i) begin
            cntQ <= cntQ + CntWidth'(1);
        end
    end

    assign terminal_o = enable_i && (cntQ == TermCount);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between an instruction fetch port and a
// data load/store port.
// Ports:
//   clk, reset                    - rising-edge clock, synchronous active-high reset
//   i_req, i_addr, i_data, i_done - fetch request/address, fetched word, completion pulse
//   d_read, d_write, d_addr,
//   d_wdata, d_rdata, d_done      - data request lines, address, store data, load data, pulse
//   mem_read, mem_write, mem_addr - memory strobes and address
//   mem_data                      - bidirectional memory data bus
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned LATENCY = MemLatency
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req,
    input  logic [WordSize-1:0] i_addr,
    output logic [WordSize-1:0] i_data,
    output logic                i_done,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [WordSize-1:0] d_addr,
    input  logic [WordSize-1:0] d_wdata,
    output logic [WordSize-1:0] d_rdata,
    output logic                d_done,
    output logic                mem_read,
    output logic                mem_write,
    output logic [WordSize-1:0] mem_addr,
    inout  wire  [WordSize-1:0] mem_data
);

    arbState_e           stateQ, stateD;
    logic                lastWasDQ, lastWasDD;
    logic [WordSize-1:0] addrQ, addrD;
    logic [WordSize-1:0] wdataQ, wdataD;
    logic                isWriteQ, isWriteD;
    logic [WordSize-1:0] iDataQ, iDataD;
    logic [WordSize-1:0] dRdataQ, dRdataD;
    logic                iDoneQ, iDoneD;
    logic                dDoneQ, dDoneD;

    logic cntClear, cntEnable, cntTerminal;
    logic iPend, dPend;

    mem_latency_counter #(
        .Latency(LATENCY)
    ) uCounter (
        .clk_i     (clk),
        .reset_i   (reset),
        .clear_i   (cntClear),
        .enable_i  (cntEnable),
        .terminal_o(cntTerminal)
    );

    // A requester whose done pulse is showing this cycle is still holding its level
    // request from the finished transaction; ignore it so it is not served twice.
    assign iPend = i_req && !iDoneQ;
    assign dPend = (d_read || d_write) && !dDoneQ;

    always_comb begin
        stateD    = stateQ;
        lastWasDD = lastWasDQ;
        addrD     = addrQ;
        wdataD    = wdataQ;
        isWriteD  = isWriteQ;
        iDataD    = iDataQ;
        dRdataD   = dRdataQ;
        iDoneD    = 1'b0;
        dDoneD    = 1'b0;
        cntClear  = 1'b0;
        cntEnable = 1'b0;

        unique case (stateQ)
            StIdle: begin
                cntClear = 1'b1;
                // Data wins unless fetch is also waiting and data had the last grant.
                if (dPend && !(iPend && lastWasDQ)) begin
                    stateD    = StBusyD;
                    lastWasDD = 1'b1;
                    addrD     = d_addr;
                    wdataD    = d_wdata;
                    isWriteD  = d_write;
                end else if (iPend) begin
                    stateD    = StBusyI;
                    lastWasDD = 1'b0;
                    addrD     = i_addr;
                    isWriteD  = 1'b0;
                end
            end
            StBusyI: begin
                cntEnable = 1'b1;
                if (cntTerminal) begin
                    iDataD   = mem_data;
                    iDoneD   = 1'b1;
                    cntClear = 1'b1;
                    stateD   = StIdle;
                end
            end
            StBusyD: begin
                cntEnable = 1'b1;
                if (cntTerminal) begin
                    if (!isWriteQ) begin
                        dRdataD = mem_data;
                    end
                    dDoneD   = 1'b1;
                    cntClear = 1'b1;
                    stateD   = StIdle;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= StIdle;
            lastWasDQ <= 1'b0;
            addrQ     <= '0;
            wdataQ    <= '0;
            isWriteQ  <= 1'b0;
            iDataQ    <= '0;
            dRdataQ   <= '0;
            iDoneQ    <= 1'b0;
            dDoneQ    <= 1'b0;
        end else begin
            stateQ    <= stateD;
            lastWasDQ <= lastWasDD;
            addrQ     <= addrD;
            wdataQ    <= wdataD;
            isWriteQ  <= isWriteD;
            iDataQ    <= iDataD;
            dRdataQ   <= dRdataD;
            iDoneQ    <= iDoneD;
            dDoneQ    <= dDoneD;
        end
    end

    logic busyI, busyD, driveData;

    assign busyI     = (stateQ == StBusyI);
    assign busyD     = (stateQ == StBusyD);
    assign driveData = busyD && isWriteQ;

    assign mem_read  = busyI || (busyD && !isWriteQ);
    assign mem_write = driveData;
    assign mem_addr  = (busyI || busyD) ? addrQ : '0;
    assign mem_data  = driveData ? wdataQ : {WordSize{1'bz}};

    assign i_data = iDataQ;
    assign i_done = iDoneQ;
    assign d_rdata = dRdataQ;
    assign d_done = dDoneQ;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by randomized
// transactions checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;

    localparam int Lat = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic [15:0] i_data;
    logic        i_done;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    wire  [15:0] mem_data;

    logic [15:0] memArr [256];
    logic [15:0] shadow [256];

    int passCnt = 0;
    int failCnt = 0;
    int totalCnt = 0;

    bit          lastWasDModel;
    logic [15:0] expI;
    logic [15:0] expD;

    mem_arbiter #(
        .LATENCY(Lat)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .i_done   (i_done),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_done   (d_done),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: combinational read onto the bus, write at the clock edge.
    assign mem_data = mem_read ? memArr[mem_addr[7:0]] : 16'bz;

    always @(posedge clk) begin
        if (mem_write) memArr[mem_addr[7:0]] <= mem_data;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        i_req = 1'b0;
        d_read = 1'b0;
        d_write = 1'b0;
        step();
        step();
        reset = 1'b0;
        lastWasDModel = 1'b0;
        expI = '0;
        expD = '0;
    endtask

    // One fetch and/or one data transaction, requests raised together in an idle cycle.
    task automatic runTxn(input bit doI, input bit doD, input bit dWr,
                          input logic [15:0] ia, input logic [15:0] da, input logic [15:0] wd);
        int eI, eD, last;
        bit firstD;
        i_req = doI;
        i_addr = ia;
        d_read = doD && !dWr;
        d_write = doD && dWr;
        d_addr = da;
        d_wdata = wd;
        eI = -1;
        eD = -1;
        if (doI && doD) begin
            firstD = !lastWasDModel;
            eD = firstD ? Lat + 1 : 2 * (Lat + 1);
            eI = firstD ? 2 * (Lat + 1) : Lat + 1;
            lastWasDModel = !firstD;
        end else if (doI) begin
            eI = Lat + 1;
            lastWasDModel = 1'b0;
        end else begin
            eD = Lat + 1;
            lastWasDModel = 1'b1;
        end
        last = (eI > eD) ? eI : eD;
        for (int n = 1; n <= last; n++) begin
            step();
            check("txn_i_done", {15'b0, i_done}, {15'b0, n == eI});
            check("txn_d_done", {15'b0, d_done}, {15'b0, n == eD});
            if (n == eI) begin
                expI = shadow[ia[7:0]];
                check("txn_i_data", i_data, expI);
                i_req = 1'b0;
            end
            if (n == eD) begin
                if (dWr) begin
                    shadow[da[7:0]] = wd;
                    check("txn_mem_written", memArr[da[7:0]], wd);
                end else begin
                    expD = shadow[da[7:0]];
                end
                check("txn_d_rdata", d_rdata, expD);
                d_read = 1'b0;
                d_write = 1'b0;
            end
        end
        step();
        check("txn_i_data_hold", i_data, expI);
        check("txn_d_rdata_hold", d_rdata, expD);
    endtask

    // Both requesters hold reads continuously; grants must alternate.
    task automatic runHeld(input int nGrants, input logic [15:0] ia, input logic [15:0] da);
        bit firstD, sideD;
        i_req = 1'b1;
        i_addr = ia;
        d_read = 1'b1;
        d_write = 1'b0;
        d_addr = da;
        firstD = !lastWasDModel;
        sideD = firstD;
        for (int k = 0; k < nGrants; k++) begin
            sideD = firstD ^ k[0];
            for (int j = 1; j <= Lat + 1; j++) begin
                step();
                if (j == 1) check("held_mem_addr", mem_addr, sideD ? da : ia);
                check("held_i_done", {15'b0, i_done}, {15'b0, (j == Lat + 1) && !sideD});
                check("held_d_done", {15'b0, d_done}, {15'b0, (j == Lat + 1) && sideD});
            end
            if (sideD) begin
                expD = shadow[da[7:0]];
                check("held_d_rdata", d_rdata, expD);
            end else begin
                expI = shadow[ia[7:0]];
                check("held_i_data", i_data, expI);
            end
        end
        lastWasDModel = sideD;
        i_req = 1'b0;
        d_read = 1'b0;
        step();
    endtask

    initial begin
        int kind;
        bit dw;
        logic [15:0] ia, da, wd;

        for (int a = 0; a < 256; a++) begin
            memArr[a] = 16'($urandom);
            shadow[a] = memArr[a];
        end
        memArr[8'h10] = 16'h1234;
        shadow[8'h10] = 16'h1234;

        // Reset state.
        doReset();
        check("rst_i_data", i_data, 16'h0);
        check("rst_d_rdata", d_rdata, 16'h0);
        check("rst_i_done", {15'b0, i_done}, 16'h0);
        check("rst_d_done", {15'b0, d_done}, 16'h0);
        check("rst_mem_read", {15'b0, mem_read}, 16'h0);
        check("rst_mem_write", {15'b0, mem_write}, 16'h0);
        check("rst_mem_addr", mem_addr, 16'h0);

        // Fetch from 0x0010: strobe in cycles 1-2, done and data in cycle 3.
        i_req = 1'b1;
        i_addr = 16'h0010;
        step();
        check("f_c1_mem_read", {15'b0, mem_read}, 16'h1);
        check("f_c1_mem_addr", mem_addr, 16'h0010);
        step();
        check("f_c2_mem_read", {15'b0, mem_read}, 16'h1);
        check("f_c2_i_done", {15'b0, i_done}, 16'h0);
        step();
        check("f_c3_i_done", {15'b0, i_done}, 16'h1);
        check("f_c3_i_data", i_data, 16'h1234);
        check("f_c3_mem_read", {15'b0, mem_read}, 16'h0);
        i_req = 1'b0;
        expI = 16'h1234;
        lastWasDModel = 1'b0;
        step();
        check("f_c4_i_done", {15'b0, i_done}, 16'h0);
        check("f_c4_i_data", i_data, 16'h1234);

        // Write 0xBEEF to 0x0020.
        d_write = 1'b1;
        d_addr = 16'h0020;
        d_wdata = 16'hBEEF;
        for (int c = 1; c <= 2; c++) begin
            step();
            check("w_mem_write", {15'b0, mem_write}, 16'h1);
            check("w_mem_read", {15'b0, mem_read}, 16'h0);
            check("w_mem_data", mem_data, 16'hBEEF);
            check("w_mem_addr", mem_addr, 16'h0020);
        end
        step();
        check("w_d_done", {15'b0, d_done}, 16'h1);
        check("w_mem_content", memArr[8'h20], 16'hBEEF);
        check("w_d_rdata_kept", d_rdata, expD);
        d_write = 1'b0;
        shadow[8'h20] = 16'hBEEF;
        lastWasDModel = 1'b1;
        step();

        // Fetch and read together from reset, then both held: D, I, D, I.
        doReset();
        runTxn(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0020, 16'h0);
        runHeld(4, 16'h0033, 16'h0044);

        // Reset in the second BUSY_D cycle aborts without a done.
        d_read = 1'b1;
        d_addr = 16'h0030;
        step();
        step();
        check("ab_c2_mem_read", {15'b0, mem_read}, 16'h1);
        reset = 1'b1;
        step();
        check("ab_d_done", {15'b0, d_done}, 16'h0);
        check("ab_mem_read", {15'b0, mem_read}, 16'h0);
        check("ab_mem_write", {15'b0, mem_write}, 16'h0);
        check("ab_mem_addr", mem_addr, 16'h0);
        check("ab_i_data", i_data, 16'h0);
        check("ab_d_rdata", d_rdata, 16'h0);
        reset = 1'b0;
        d_read = 1'b0;
        expI = '0;
        expD = '0;
        lastWasDModel = 1'b0;
        step();
        check("ab_next_d_done", {15'b0, d_done}, 16'h0);

        // Read and write both set: a write; address change mid-flight ignored.
        wd = 16'($urandom);
        d_read = 1'b1;
        d_write = 1'b1;
        d_addr = 16'h0040;
        d_wdata = wd;
        step();
        check("rw_mem_write", {15'b0, mem_write}, 16'h1);
        check("rw_mem_read", {15'b0, mem_read}, 16'h0);
        check("rw_mem_data", mem_data, wd);
        check("rw_mem_addr", mem_addr, 16'h0040);
        d_addr = 16'h0041;
        d_wdata = ~wd;
        step();
        check("rw_c2_mem_addr", mem_addr, 16'h0040);
        check("rw_c2_mem_read", {15'b0, mem_read}, 16'h0);
        check("rw_c2_mem_data", mem_data, wd);
        step();
        check("rw_d_done", {15'b0, d_done}, 16'h1);
        check("rw_mem_content", memArr[8'h40], wd);
        check("rw_d_rdata_kept", d_rdata, expD);
        d_read = 1'b0;
        d_write = 1'b0;
        shadow[8'h40] = wd;
        lastWasDModel = 1'b1;
        step();

        // Randomized transactions against the model.
        for (int r = 0; r < 30; r++) begin
            kind = int'($urandom_range(0, 3));
            dw = 1'($urandom_range(0, 1));
            ia = 16'($urandom_range(0, 255));
            da = 16'($urandom_range(0, 255));
            wd = 16'($urandom);
            runTxn(kind == 0 || kind == 3, kind != 0, kind == 2 || (kind == 3 && dw),
                   ia, da, wd);
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
